// File: rtl/uart_frame_responder.sv
// uart_frame_responder
// Parses 4-byte command frames (header, command, argument, checksum) from the
// UART receive strobe interface, publishes accepted commands and queues a
// one-byte ACK/NAK reply to the UART transmit path.
// Optional feature macro: FRAME_CHECKSUM_EN. When it is defined the checksum
// byte is verified; otherwise every complete frame is accepted and Err_Cnt
// counts inter-byte timeouts only.
module uart_frame_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter logic [7:0]  ACK_OK         = 8'h5A,
  parameter logic [7:0]  ACK_ERR        = 8'hEE
) (
  input  logic       clk_100MHz,
  input  logic       Rst,
  input  logic       Rx_Valid,
  input  logic [7:0] Rx_Byte,
  input  logic       Tx_Busy,
  output logic       Cmd_Valid,
  output logic [7:0] Cmd,
  output logic [7:0] Arg,
  output logic       Tx_Start,
  output logic [7:0] Tx_Byte,
  output logic [7:0] Err_Cnt
);

  typedef enum logic [2:0] {
    WAIT_HDR,
    GET_CMD,
    GET_ARG,
    GET_SUM,
    CHECK,
    RESP_WAIT
  } state_t;

  // Last idle count before a partial frame is abandoned.
  localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [23:0] timer;
  logic [7:0]  cmd_q;
  logic [7:0]  arg_q;
  logic [7:0]  reply_q;
  logic        sum_ok;

`ifdef FRAME_CHECKSUM_EN
  logic [7:0]  sum_q;

  // Frame passes when the 8-bit wrapped sum of command and argument matches.
  always_comb begin
    sum_ok = ((cmd_q + arg_q) == sum_q);
  end
`else
  // Checksum byte is consumed but never compared, so every frame passes.
  always_comb begin
    sum_ok = 1'b1;
  end
`endif

  // Error counter that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

  // Frame parser, inter-byte timeout, checksum decision and reply handshake.
  // NOTE: every register here is assigned with <= so all reads in this block
  // see the pre-edge values regardless of statement order.
  always_ff @(posedge clk_100MHz or negedge Rst) begin
    if (!Rst) begin
      state     <= WAIT_HDR;
      timer     <= '0;
      cmd_q     <= '0;
      arg_q     <= '0;
      reply_q   <= '0;
`ifdef FRAME_CHECKSUM_EN
      sum_q     <= '0;
`endif
      Cmd_Valid <= 1'b0;
      Cmd       <= '0;
      Arg       <= '0;
      Tx_Start  <= 1'b0;
      Tx_Byte   <= '0;
      Err_Cnt   <= '0;
    end else begin
      // Strobes default low so each assertion lasts exactly one cycle.
      Cmd_Valid <= 1'b0;
      Tx_Start  <= 1'b0;

      case (state)
        WAIT_HDR: begin
          if (Rx_Valid && (Rx_Byte == HEADER)) begin
            state <= GET_CMD;
            timer <= '0;
          end
        end

        GET_CMD, GET_ARG, GET_SUM: begin
          if (Rx_Valid) begin
            // A received byte always beats a timeout in the same cycle.
            timer <= '0;
            case (state)
              GET_CMD: begin
                cmd_q <= Rx_Byte;
                state <= GET_ARG;
              end
              GET_ARG: begin
                arg_q <= Rx_Byte;
                state <= GET_SUM;
              end
              default: begin
`ifdef FRAME_CHECKSUM_EN
                sum_q <= Rx_Byte;
`endif
                state <= CHECK;
              end
            endcase
          end else if (timer == TIMEOUT_LAST) begin
            state   <= WAIT_HDR;
            Err_Cnt <= sat_inc(Err_Cnt);
          end else begin
            timer <= timer + 24'd1;
          end
        end

        CHECK: begin
          if (sum_ok) begin
            Cmd       <= cmd_q;
            Arg       <= arg_q;
            Cmd_Valid <= 1'b1;
            reply_q   <= ACK_OK;
          end else begin
            Err_Cnt   <= sat_inc(Err_Cnt);
            reply_q   <= ACK_ERR;
          end
          state <= RESP_WAIT;
        end

        RESP_WAIT: begin
          // Holds indefinitely until the transmitter can take the reply.
          if (!Tx_Busy) begin
            Tx_Byte  <= reply_q;
            Tx_Start <= 1'b1;
            state    <= WAIT_HDR;
          end
        end

        default: state <= WAIT_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_responder.sv
// Testbench for uart_frame_responder: a frame-level reference model is
// compared against the DUT on every falling edge, and directed scenarios add
// hand-computed literal expectations.
`timescale 1ns/1ps
module tb_uart_frame_responder;

  localparam int unsigned T_OUT = 1000;
  localparam logic [7:0]  HDR   = 8'hA5;
  localparam logic [7:0]  OK    = 8'h5A;
  localparam logic [7:0]  BAD   = 8'hEE;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte  = 8'h00;
  logic       tx_busy  = 1'b0;
  logic       cmd_valid;
  logic [7:0] cmd;
  logic [7:0] arg;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic [7:0] err_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_cv   = 0;
  int n_ts   = 0;

  always #5 clk = ~clk;

  uart_frame_responder #(
    .TIMEOUT_CYCLES(T_OUT),
    .HEADER        (HDR),
    .ACK_OK        (OK),
    .ACK_ERR       (BAD)
  ) dut (
    .clk_100MHz(clk),
    .Rst       (rst),
    .Rx_Valid  (rx_valid),
    .Rx_Byte   (rx_byte),
    .Tx_Busy   (tx_busy),
    .Cmd_Valid (cmd_valid),
    .Cmd       (cmd),
    .Arg       (arg),
    .Tx_Start  (tx_start),
    .Tx_Byte   (tx_byte),
    .Err_Cnt   (err_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  logic [7:0] frame[$];
  int         m_idle     = 0;
  bit         decide     = 1'b0;
  bit         reply_pend = 1'b0;
  logic [7:0] m_reply    = 8'h00;
  logic       m_cv       = 1'b0;
  logic [7:0] m_cmd      = 8'h00;
  logic [7:0] m_arg      = 8'h00;
  logic       m_ts       = 1'b0;
  logic [7:0] m_tb       = 8'h00;
  logic [7:0] m_err      = 8'h00;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame.delete();
      m_idle = 0; decide = 0; reply_pend = 0; m_reply = 0;
      m_cv = 0; m_cmd = 0; m_arg = 0; m_ts = 0; m_tb = 0; m_err = 0;
    end else begin
      bit pass;
      m_cv = 0;
      m_ts = 0;
      if (decide) begin
        decide = 0;
`ifdef FRAME_CHECKSUM_EN
        pass = ((int'(frame[1]) + int'(frame[2])) % 256) == int'(frame[3]);
`else
        pass = 1'b1;
`endif
        if (pass) begin
          m_cv = 1; m_cmd = frame[1]; m_arg = frame[2]; m_reply = OK;
        end else begin
          if (m_err != 8'hFF) m_err = m_err + 1;
          m_reply = BAD;
        end
        frame.delete();
        reply_pend = 1;
      end else if (reply_pend) begin
        if (!tx_busy) begin
          m_ts = 1; m_tb = m_reply; reply_pend = 0;
        end
      end else if (frame.size() == 0) begin
        if (rx_valid && rx_byte == HDR) begin
          frame.push_back(rx_byte);
          m_idle = 0;
        end
      end else begin
        if (rx_valid) begin
          frame.push_back(rx_byte);
          m_idle = 0;
          if (frame.size() == 4) decide = 1;
        end else begin
          m_idle++;
          if (m_idle == int'(T_OUT)) begin
            frame.delete();
            if (m_err != 8'hFF) m_err = m_err + 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("cmd_valid", cmd_valid, m_cv);
    check("cmd",       cmd,       m_cmd);
    check("arg",       arg,       m_arg);
    check("tx_start",  tx_start,  m_ts);
    check("tx_byte",   tx_byte,   m_tb);
    check("err_cnt",   err_cnt,   m_err);
    if (cmd_valid === 1'b1) n_cv++;
    if (tx_start === 1'b1) n_ts++;
  end

  // ---------------- stimulus helpers (start and end on a falling edge) ----------------
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cv"},  cmd_valid, 0);
    check({tag, "_cmd"}, cmd,       0);
    check({tag, "_arg"}, arg,       0);
    check({tag, "_ts"},  tx_start,  0);
    check({tag, "_tb"},  tx_byte,   0);
    check({tag, "_err"}, err_cnt,   0);
  endtask

  int cv0, ts0;

  initial begin
    // Power-on reset.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    #2 rst = 1'b1;
    @(negedge clk);

    // T1: good frame, exact pulse timing.
    cv0 = n_cv; ts0 = n_ts;
    send(HDR); send(8'h10); send(8'h22); send(8'h32);
    check("t1_cv_in_check", cmd_valid, 0);
    @(negedge clk);
    check("t1_cv", cmd_valid, 1);
    check("t1_cmd", cmd, 8'h10);
    check("t1_arg", arg, 8'h22);
    check("t1_ts_early", tx_start, 0);
    @(negedge clk);
    check("t1_ts", tx_start, 1);
    check("t1_tb", tx_byte, 8'h5A);
    check("t1_cv_one", cmd_valid, 0);
    @(negedge clk);
    check("t1_ts_one", tx_start, 0);
    wait_cycles(3);
    check("t1_ncv", n_cv - cv0, 1);
    check("t1_nts", n_ts - ts0, 1);
    check("t1_err", err_cnt, 0);

    // T2: bad checksum.
    do_reset();
    cv0 = n_cv; ts0 = n_ts;
    send(HDR); send(8'h10); send(8'h22); send(8'h33);
    wait_cycles(5);
    check("t2_nts", n_ts - ts0, 1);
`ifdef FRAME_CHECKSUM_EN
    check("t2_ncv", n_cv - cv0, 0);
    check("t2_cmd", cmd, 8'h00);
    check("t2_arg", arg, 8'h00);
    check("t2_tb", tx_byte, 8'hEE);
    check("t2_err", err_cnt, 1);
`else
    check("t2_ncv", n_cv - cv0, 1);
    check("t2_cmd", cmd, 8'h10);
    check("t2_arg", arg, 8'h22);
    check("t2_tb", tx_byte, 8'h5A);
    check("t2_err", err_cnt, 0);
`endif

    // T3: junk before the header is discarded silently.
    do_reset();
    cv0 = n_cv; ts0 = n_ts;
    send(8'h00); send(8'hFF); send(8'h5A);
    wait_cycles(2);
    send(HDR); send(8'h01); send(8'h02); send(8'h03);
    wait_cycles(5);
    check("t3_ncv", n_cv - cv0, 1);
    check("t3_cmd", cmd, 8'h01);
    check("t3_arg", arg, 8'h02);
    check("t3_nts", n_ts - ts0, 1);
    check("t3_tb", tx_byte, 8'h5A);
    check("t3_err", err_cnt, 0);

    // T4: inter-byte timeout, then recovery.
    do_reset();
    cv0 = n_cv; ts0 = n_ts;
    send(HDR); send(8'h10);
    wait_cycles(T_OUT);
    check("t4_err", err_cnt, 1);
    check("t4_nts", n_ts - ts0, 0);
    check("t4_ncv", n_cv - cv0, 0);
    send(HDR); send(8'h07); send(8'h08); send(8'h0F);
    wait_cycles(5);
    check("t4_ncv2", n_cv - cv0, 1);
    check("t4_cmd", cmd, 8'h07);
    check("t4_arg", arg, 8'h08);
    check("t4_err2", err_cnt, 1);

    // T4b: a byte on the last idle cycle before timeout still wins.
    cv0 = n_cv;
    send(HDR);
    wait_cycles(T_OUT - 1); send(8'h10);
    wait_cycles(T_OUT - 1); send(8'h20);
    wait_cycles(T_OUT - 1); send(8'h30);
    wait_cycles(5);
    check("t4b_ncv", n_cv - cv0, 1);
    check("t4b_cmd", cmd, 8'h10);
    check("t4b_arg", arg, 8'h20);
    check("t4b_err", err_cnt, 1);

    // T5: reply held off by Tx_Busy; bytes during the wait are dropped.
    do_reset();
    cv0 = n_cv; ts0 = n_ts;
    tx_busy = 1'b1;
    send(HDR); send(8'h01); send(8'h02); send(8'h03);
    send(HDR); send(8'h01);
    wait_cycles(500);
    check("t5_nts_busy", n_ts - ts0, 0);
    check("t5_ncv", n_cv - cv0, 1);
    tx_busy = 1'b0;
    @(negedge clk);
    check("t5_ts", tx_start, 1);
    check("t5_tb", tx_byte, 8'h5A);
    wait_cycles(3);
    check("t5_ncv2", n_cv - cv0, 1);
    check("t5_nts", n_ts - ts0, 1);
    check("t5_err", err_cnt, 0);

    // T6: reset mid-frame discards the partial frame.
    cv0 = n_cv; ts0 = n_ts;
    send(HDR); send(8'h10);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("t6_rst");
    #2 rst = 1'b1;
    @(negedge clk);
    send(8'h22); send(8'h32);
    wait_cycles(5);
    check("t6_ncv", n_cv - cv0, 0);
    check("t6_nts", n_ts - ts0, 0);

    // T7: error counter behaviour over many bad-checksum frames.
    do_reset();
    repeat (260) begin
      send(HDR); send(8'h01); send(8'h01); send(8'h00);
      wait_cycles(3);
    end
`ifdef FRAME_CHECKSUM_EN
    check("t7_err_sat", err_cnt, 8'hFF);
    check("t7_tb", tx_byte, 8'hEE);
`else
    check("t7_err", err_cnt, 0);
    check("t7_tb", tx_byte, 8'h5A);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
